// File: rtl/serial_subtractor_pkg.sv
// Purpose: shared types and the one-bit full-subtractor function for serial_subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic d;   // difference bit
        logic bo;  // borrow out
    } fs_out_t;

    // One bit of x - y - bi.
    function automatic fs_out_t fs_bit(input logic x, input logic y, input logic bi);
        fs_out_t r;
        r.d  = x ^ y ^ bi;
        r.bo = (~x & y) | (~(x ^ y) & bi);
        return r;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Purpose: combinational one-bit full subtractor, d = x - y - bi with borrow bo.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent owns sequencing and the borrow register.
// Ports: x, y, bi (inputs); d, bo (outputs).
module fs_cell
    import serial_subtractor_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    fs_out_t r;

    assign r  = fs_bit(x, y, bi);
    assign d  = r.d;
    assign bo = r.bo;

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Latency: start accepted at edge 0, bits at edges 1..WIDTH, done pulses in the cycle after edge WIDTH.
// Backpressure: start is ignored while busy; one operation per WIDTH+2 cycles with start held high.
// Ports: clk, rst_n (async active-low); start, a, b, bin in; busy, done, diff, borrow_out out.
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res_sh;
    logic              br;
    logic [CNT_W-1:0]  cnt;
    logic              cell_d;
    logic              cell_bo;
    logic              last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    fs_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {cell_d, res_sh[WIDTH-1:1]};
                    br     <= cell_bo;
                    cnt    <= cnt + CNT_W'(1);
                    // Results are published only on the edge entering DONE.
                    if (last_bit) begin
                        diff       <= {cell_d, res_sh[WIDTH-1:1]};
                        borrow_out <= cell_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // On the final step a_sh[0]/b_sh[0] are the operand sign bits.
                        ovf        <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ cell_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
